// File: rtl/pic_pkg.sv
// Shared definitions for the picture selector and the SD image loader:
// controller state encoding and card layout constants.
package pic_pkg;

    typedef enum logic [2:0] {
        ST_BOOT = 3'd0,
        ST_IDLE = 3'd1,
        ST_CALC = 3'd2,
        ST_REQ  = 3'd3,
        ST_WAIT = 3'd4
    } pic_state_e;

    localparam int SD_BLK_BYTES    = 512;
    // 320x240 pixels at 16 bpp = 153600 bytes = 300 blocks of 512 bytes
    localparam int DEF_BLK_PER_IMG = 300;
    localparam int DEF_NUM_IMG     = 16;

endpackage

// File: rtl/pic_idx_wrap.sv
// Next picture index for an incr/decr command, wrapping modulo NUM_IMG.
// Neither or both flags set leaves the index unchanged.
module pic_idx_wrap
    import pic_pkg::*;
#(
    parameter int NUM_IMG = DEF_NUM_IMG,
    parameter int IDX_W   = 8
) (
    input  logic [IDX_W-1:0] cur_idx,
    input  logic             incr,
    input  logic             decr,
    output logic [IDX_W-1:0] next_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IMG - 1);

    always_comb begin
        next_idx = cur_idx;
        if (incr && !decr) begin
            next_idx = (cur_idx == LAST_IDX) ? '0 : cur_idx + IDX_W'(1);
        end else if (decr && !incr) begin
            next_idx = (cur_idx == '0) ? LAST_IDX : cur_idx - IDX_W'(1);
        end
    end

endmodule

// File: rtl/pic_sel.sv
// Picture selector: turns incr/decr/here commands into SD load requests and
// blocks further commands until the loader reports done or error.
module pic_sel
    import pic_pkg::*;
#(
    parameter int NUM_IMG     = DEF_NUM_IMG,
    parameter int IDX_W       = 8,
    parameter int BLK_PER_IMG = DEF_BLK_PER_IMG,
    parameter int BASE_BLK    = 0,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ctl_valid,
    output logic              ctl_ready,
    input  logic              ctl_incr,
    input  logic              ctl_decr,
    output logic              load_valid,
    input  logic              load_ready,
    output logic [ADDR_W-1:0] load_addr,
    input  logic              load_done,
    input  logic              load_err,
    output logic [IDX_W-1:0]  cur_idx,
    output logic              busy,
    output logic              err
);

    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_BLK);
    localparam logic [ADDR_W-1:0] BLK_A  = ADDR_W'(BLK_PER_IMG);

    pic_state_e        state;
    pic_state_e        next_state;
    logic              accept;
    logic              boot_ld;
    logic              calc_ld;
    logic              set_err;
    logic              clr_err;
    logic [IDX_W-1:0]  next_idx;
    logic [ADDR_W-1:0] calc_addr;

    pic_idx_wrap #(
        .NUM_IMG (NUM_IMG),
        .IDX_W   (IDX_W)
    ) u_idx_wrap (
        .cur_idx  (cur_idx),
        .incr     (ctl_incr),
        .decr     (ctl_decr),
        .next_idx (next_idx)
    );

    // Wraps modulo 2^ADDR_W by construction of the operand widths.
    assign calc_addr = BASE_A + ADDR_W'(cur_idx) * BLK_A;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_BOOT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        boot_ld    = 1'b0;
        calc_ld    = 1'b0;
        set_err    = 1'b0;
        clr_err    = 1'b0;
        case (state)
            ST_BOOT: begin
                boot_ld    = 1'b1;
                next_state = ST_REQ;
            end
            ST_IDLE: begin
                if (ctl_valid) begin
                    accept     = 1'b1;
                    next_state = ST_CALC;
                end
            end
            ST_CALC: begin
                calc_ld    = 1'b1;
                next_state = ST_REQ;
            end
            ST_REQ: begin
                if (load_ready) begin
                    next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A simultaneous done and err is treated as a failure.
                if (load_err) begin
                    set_err    = 1'b1;
                    next_state = ST_IDLE;
                end else if (load_done) begin
                    clr_err    = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_idx   <= '0;
            load_addr <= BASE_A;
            err       <= 1'b0;
        end else begin
            if (accept) begin
                cur_idx <= next_idx;
            end
            if (boot_ld) begin
                load_addr <= BASE_A;
            end else if (calc_ld) begin
                load_addr <= calc_addr;
            end
            if (set_err) begin
                err <= 1'b1;
            end else if (clr_err) begin
                err <= 1'b0;
            end
        end
    end

    // Decoded straight from state so an async reset drops them at once.
    assign load_valid = (state == ST_REQ);
    assign ctl_ready  = (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_pic_sel.sv
// Self-checking bench for pic_sel: directed and random commands against an
// arithmetic index/address model, with a bench-driven SD loader.
module tb_pic_sel;

    localparam int NUM_IMG = 4;
    localparam int IDX_W   = 8;
    localparam int BLK     = 300;
    localparam int BASE    = 8192;
    localparam int ADDR_W  = 32;

    logic              clk        = 1'b0;
    logic              rst_n      = 1'b0;
    logic              ctl_valid  = 1'b0;
    logic              ctl_incr   = 1'b0;
    logic              ctl_decr   = 1'b0;
    logic              load_ready = 1'b0;
    logic              load_done  = 1'b0;
    logic              load_err   = 1'b0;
    logic              ctl_ready;
    logic              load_valid;
    logic [ADDR_W-1:0] load_addr;
    logic [IDX_W-1:0]  cur_idx;
    logic              busy;
    logic              err;

    int   checks    = 0;
    int   errors    = 0;
    int   model_idx = 0;
    logic model_err = 1'b0;
    int   r;
    int   m;

    pic_sel #(
        .NUM_IMG     (NUM_IMG),
        .IDX_W       (IDX_W),
        .BLK_PER_IMG (BLK),
        .BASE_BLK    (BASE),
        .ADDR_W      (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ctl_valid  (ctl_valid),
        .ctl_ready  (ctl_ready),
        .ctl_incr   (ctl_incr),
        .ctl_decr   (ctl_decr),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_addr  (load_addr),
        .load_done  (load_done),
        .load_err   (load_err),
        .cur_idx    (cur_idx),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    function automatic int ref_idx(input int idx, input bit inc, input bit dec);
        if (inc && !dec) return (idx + 1) % NUM_IMG;
        if (dec && !inc) return (idx + NUM_IMG - 1) % NUM_IMG;
        return idx;
    endfunction

    function automatic logic [63:0] ref_addr(input int idx);
        return 64'(BASE + idx * BLK);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Plays the SD loader: ready 3 cycles into REQ, done/err ~20 cycles later.
    // mode 0 = done, 1 = err, 2 = done and err together.
    task automatic serve_load(input int mode);
        int n = 0;
        while (load_valid !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        checkOutput("load_valid_seen", 64'(load_valid), 64'd1);
        checkOutput("load_addr", 64'(load_addr), ref_addr(model_idx));
        checkOutput("cur_idx", 64'(cur_idx), 64'(model_idx));
        checkOutput("ctl_ready_req", 64'(ctl_ready), 64'd0);
        load_done = 1'b1;
        load_err  = 1'b1;
        @(negedge clk);
        load_done = 1'b0;
        load_err  = 1'b0;
        checkOutput("req_ignores_done_err", 64'(load_valid), 64'd1);
        checkOutput("req_err_unchanged", 64'(err), 64'(model_err));
        @(negedge clk);
        checkOutput("load_addr_stable", 64'(load_addr), ref_addr(model_idx));
        load_ready = 1'b1;
        @(negedge clk);
        load_ready = 1'b0;
        checkOutput("load_valid_drop", 64'(load_valid), 64'd0);
        checkOutput("busy_wait", 64'(busy), 64'd1);
        repeat (18) @(negedge clk);
        checkOutput("ctl_ready_wait", 64'(ctl_ready), 64'd0);
        checkOutput("cur_idx_wait", 64'(cur_idx), 64'(model_idx));
        load_done = (mode != 1);
        load_err  = (mode != 0);
        @(negedge clk);
        load_done = 1'b0;
        load_err  = 1'b0;
        model_err = (mode != 0);
        checkOutput("ctl_ready_after_done", 64'(ctl_ready), 64'd1);
        checkOutput("busy_idle", 64'(busy), 64'd0);
        checkOutput("err_flag", 64'(err), 64'(model_err));
    endtask

    // Called on the negedge right after the accepting clock edge.
    task automatic after_accept();
        ctl_valid = 1'b0;
        ctl_incr  = 1'b0;
        ctl_decr  = 1'b0;
        checkOutput("cur_idx_update", 64'(cur_idx), 64'(model_idx));
        checkOutput("busy_calc", 64'(busy), 64'd1);
        checkOutput("ctl_ready_calc", 64'(ctl_ready), 64'd0);
        checkOutput("latency_not_yet", 64'(load_valid), 64'd0);
        @(negedge clk);
        checkOutput("latency_2", 64'(load_valid), 64'd1);
    endtask

    task automatic applyStimulus(input bit inc, input bit dec);
        ctl_valid = 1'b1;
        ctl_incr  = inc;
        ctl_decr  = dec;
        model_idx = ref_idx(model_idx, inc, dec);
        @(negedge clk);
        after_accept();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("rst_load_valid", 64'(load_valid), 64'd0);
        checkOutput("rst_ctl_ready", 64'(ctl_ready), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd1);
        checkOutput("rst_cur_idx", 64'(cur_idx), 64'd0);
        checkOutput("rst_load_addr", 64'(load_addr), 64'(BASE));
        checkOutput("rst_err", 64'(err), 64'd0);

        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("boot_latency", 64'(load_valid), 64'd1);
        serve_load(0);

        $display("[TB] incr sweep and decr wrap");
        repeat (4) begin
            applyStimulus(1'b1, 1'b0);
            serve_load(0);
        end
        applyStimulus(1'b0, 1'b1);
        serve_load(0);
        applyStimulus(1'b1, 1'b1);
        serve_load(0);

        $display("[TB] command held through WAIT");
        applyStimulus(1'b1, 1'b0);
        ctl_valid = 1'b1;
        ctl_incr  = 1'b1;
        serve_load(0);
        model_idx = ref_idx(model_idx, 1'b1, 1'b0);
        @(negedge clk);
        after_accept();
        serve_load(0);

        $display("[TB] error handling");
        applyStimulus(1'b0, 1'b0);
        serve_load(1);
        applyStimulus(1'b0, 1'b0);
        serve_load(0);
        applyStimulus(1'b1, 1'b0);
        serve_load(2);

        $display("[TB] random commands");
        for (int i = 0; i < 10; i++) begin
            r = int'($urandom_range(0, 3));
            m = ($urandom_range(0, 3) == 0) ? 1 : 0;
            applyStimulus(r[0], r[1]);
            serve_load(m);
        end

        $display("[TB] reset during REQ");
        applyStimulus(1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_drops_valid", 64'(load_valid), 64'd0);
        checkOutput("reset_cur_idx", 64'(cur_idx), 64'd0);
        checkOutput("reset_load_addr", 64'(load_addr), 64'(BASE));
        checkOutput("reset_err", 64'(err), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd1);
        model_idx = 0;
        model_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("boot_after_reset", 64'(load_valid), 64'd1);
        serve_load(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
